// File: rtl/temp_sample_ctrl_if.sv
// Avalon-MM slave bus bundle for the temperature sampling controller.
// Word addressed, zero wait-state, with read data registered in the slave.
interface temp_sample_ctrl_if;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, write, read, writedata, input readdata);
    modport slave  (input address, write, read, writedata, output readdata);
endinterface

// File: rtl/temp_sample_ctrl.sv
// Periodic temperature sampler: averages four sensor samples per update and drives
// heater/fan with hysteresis, exposing control/status through an Avalon-MM register map.
module temp_sample_ctrl (
    input  logic                clk,
    input  logic                reset_n,
    temp_sample_ctrl_if.slave   avs,
    output logic                sns_req,
    input  logic                sns_ack,
    input  logic [7:0]          sns_data,
    output logic                heater_on,
    output logic                fan_on,
    output logic                irq
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned TMO_W  = 8;
    localparam int unsigned TEMP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_REQ, S_ACCUM, S_UPDATE
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_PERIOD = 3'd1;
    localparam logic [2:0] A_THRESH = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_LAST   = 3'd4;

    state_t              r_state, w_state_nxt;
    logic                r_enable, r_irq_en;
    logic [CNT_W-1:0]    r_period, r_cnt;
    logic [TEMP_W-1:0]   r_t_low, r_t_high, r_avg, r_last;
    logic [3:0]          r_hyst;
    logic                r_done, r_err, r_heater, r_fan, r_sns_req;
    logic [TMO_W-1:0]    r_timeout;
    logic [SUM_W-1:0]    r_sum;
    logic [1:0]          r_count;
    logic [31:0]         r_readdata;

    logic                w_clear, w_reload, w_cnt_dec, w_capture, w_timeout;
    logic                w_to_inc, w_count_inc, w_update, w_ack;
    logic [CNT_W-1:0]    w_period_eff;
    logic [TEMP_W-1:0]   w_avg_new, w_heater_off, w_fan_off;
    logic [TEMP_W:0]     w_heater_sum;
    logic                w_heater_set, w_fan_set, w_heater_nxt, w_fan_nxt;
    logic                w_w1c_done, w_w1c_err;
    logic [31:0]         w_rd_mux;
    logic                w_unused;

    assign w_unused     = &{1'b0, avs.writedata[31:20]};
    assign w_ack        = sns_ack & r_sns_req;
    assign w_period_eff = (r_period == '0) ? CNT_W'(1) : r_period;

    // Sequencer next state and datapath strobes; a cleared enable overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_reload    = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_to_inc    = 1'b0;
        w_count_inc = 1'b0;
        w_update    = 1'b0;
        if (!r_enable) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_TICK;
                    w_reload    = 1'b1;
                end
                S_WAIT_TICK: begin
                    if (r_cnt <= CNT_W'(1)) w_state_nxt = S_REQ;
                    else                    w_cnt_dec   = 1'b1;
                end
                S_REQ: begin
                    if (w_ack) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_ACCUM;
                    end else if (r_timeout == {TMO_W{1'b1}}) begin
                        w_timeout   = 1'b1;
                        w_reload    = 1'b1;
                        w_state_nxt = S_WAIT_TICK;
                    end else begin
                        w_to_inc    = 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (r_count == 2'd3) begin
                        w_state_nxt = S_UPDATE;
                    end else begin
                        w_count_inc = 1'b1;
                        w_reload    = 1'b1;
                        w_state_nxt = S_WAIT_TICK;
                    end
                end
                S_UPDATE: begin
                    w_update    = 1'b1;
                    w_reload    = 1'b1;
                    w_state_nxt = S_WAIT_TICK;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_sns_req <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sns_req <= (w_state_nxt == S_REQ);
        end
    end

    // Slot counter, timeout counter and sample accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_timeout <= '0;
            r_sum     <= '0;
            r_count   <= '0;
            r_last    <= '0;
            r_avg     <= '0;
        end else begin
            if (w_clear)        r_cnt <= '0;
            else if (w_reload)  r_cnt <= w_period_eff;
            else if (w_cnt_dec) r_cnt <= CNT_W'(r_cnt - CNT_W'(1));

            if (w_clear || w_capture || w_timeout) r_timeout <= '0;
            else if (w_to_inc)                     r_timeout <= TMO_W'(r_timeout + TMO_W'(1));

            if (w_clear || w_update) begin
                r_sum   <= '0;
                r_count <= '0;
            end else begin
                if (w_capture)   r_sum   <= SUM_W'(r_sum + SUM_W'(sns_data));
                if (w_count_inc) r_count <= 2'(r_count + 2'd1);
            end

            if (w_capture) r_last <= sns_data;
            if (w_update)  r_avg  <= w_avg_new;
        end
    end

    // Hysteresis thresholds saturate at the ends of the 8-bit range.
    assign w_avg_new    = r_sum[SUM_W-1:2];
    assign w_heater_sum = (TEMP_W+1)'(r_t_low) + (TEMP_W+1)'(r_hyst);
    assign w_heater_off = w_heater_sum[TEMP_W] ? {TEMP_W{1'b1}} : w_heater_sum[TEMP_W-1:0];
    assign w_fan_off    = (r_t_high > TEMP_W'(r_hyst)) ? TEMP_W'(r_t_high - TEMP_W'(r_hyst)) : '0;
    assign w_heater_set = (w_avg_new < r_t_low);
    assign w_fan_set    = (w_avg_new > r_t_high);

    // A freshly set actuator wins over one only holding inside its band.
    always_comb begin
        w_heater_nxt = r_heater;
        w_fan_nxt    = r_fan;
        if (w_heater_set)                  w_heater_nxt = 1'b1;
        else if (w_avg_new >= w_heater_off) w_heater_nxt = 1'b0;
        if (w_fan_set)                     w_fan_nxt = 1'b1;
        else if (w_avg_new <= w_fan_off)   w_fan_nxt = 1'b0;
        if (w_heater_nxt && w_fan_nxt) begin
            if (w_heater_set) w_fan_nxt    = 1'b0;
            else              w_heater_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_heater <= 1'b0;
            r_fan    <= 1'b0;
        end else if (r_t_low > r_t_high) begin
            r_heater <= 1'b0;
            r_fan    <= 1'b0;
        end else if (w_update) begin
            r_heater <= w_heater_nxt;
            r_fan    <= w_fan_nxt;
        end
    end

    // Software-writable configuration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_period <= CNT_W'(16'h03E8);
            r_t_low  <= TEMP_W'(18);
            r_t_high <= TEMP_W'(30);
            r_hyst   <= 4'd2;
        end else if (avs.write) begin
            case (avs.address)
                A_CTRL: begin
                    r_enable <= avs.writedata[0];
                    r_irq_en <= avs.writedata[1];
                end
                A_PERIOD: r_period <= avs.writedata[15:0];
                A_THRESH: begin
                    r_t_low  <= avs.writedata[7:0];
                    r_t_high <= avs.writedata[15:8];
                    r_hyst   <= avs.writedata[19:16];
                end
                default: ;
            endcase
        end
    end

    // Sticky flags: a hardware set in the same cycle beats a write-one-to-clear.
    assign w_w1c_done = avs.write && (avs.address == A_STATUS) && avs.writedata[8];
    assign w_w1c_err  = avs.write && (avs.address == A_STATUS) && avs.writedata[9];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_update  | (r_done & ~w_w1c_done);
            r_err  <= w_timeout | (r_err  & ~w_w1c_err);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs.address)
            A_CTRL:   w_rd_mux = {30'd0, r_irq_en, r_enable};
            A_PERIOD: w_rd_mux = {16'd0, r_period};
            A_THRESH: w_rd_mux = {12'd0, r_hyst, r_t_high, r_t_low};
            A_STATUS: w_rd_mux = {20'd0, r_fan, r_heater, r_err, r_done, r_avg};
            A_LAST:   w_rd_mux = {24'd0, r_last};
            default:  w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_readdata <= '0;
        else if (avs.read) r_readdata <= w_rd_mux;
    end

    assign avs.readdata = r_readdata;
    assign sns_req      = r_sns_req;
    assign heater_on    = r_heater;
    assign fan_on       = r_fan;
    assign irq          = r_irq_en & (r_done | r_err);
endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Bench for temp_sample_ctrl: register-map vector table, hand-written sequencer
// corner cases, then randomized batches checked against a four-sample average model.
module tb_temp_sample_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       sns_req, sns_ack, heater_on, fan_on, irq;
    logic [7:0] sns_data;

    temp_sample_ctrl_if bus ();

    temp_sample_ctrl u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avs       (bus),
        .sns_req   (sns_req),
        .sns_ack   (sns_ack),
        .sns_data  (sns_data),
        .heater_on (heater_on),
        .fan_on    (fan_on),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t       vecs [20];
    logic [7:0] sample_q [$];
    logic [7:0] batch [4];
    bit         force_ack = 1'b0;
    int         req_age = 0;

    // Reference state: thresholds, actuators, last sample, error flag.
    int m_tl = 18, m_th = 30, m_hy = 2;
    bit m_h = 1'b0, m_f = 1'b0, m_err = 1'b0;
    int m_last = 0;

    // Sensor: acknowledges one cycle into a request, only while samples are queued.
    always @(negedge clk) begin
        if (force_ack) begin
            sns_ack  = 1'b1;
            sns_data = 8'hFF;
        end else if (sns_req && sample_q.size() > 0) begin
            if (req_age == 1) begin
                sns_ack  = 1'b1;
                sns_data = sample_q.pop_front();
            end else begin
                sns_ack = 1'b0;
            end
            req_age++;
        end else begin
            sns_ack = 1'b0;
            if (!sns_req) req_age = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        bus.read    = 1'b0;
        d = bus.readdata;
    endtask

    task automatic set_thresh(input int tl, input int th, input int hy);
        bus_write(3'd2, {12'd0, 4'(hy), 8'(th), 8'(tl)});
        m_tl = tl; m_th = th; m_hy = hy;
        if (tl > th) begin m_h = 1'b0; m_f = 1'b0; end
    endtask

    task automatic start(input bit ie);
        bus_write(3'd0, {30'd0, ie, 1'b1});
    endtask

    task automatic stop(input bit ie);
        bus_write(3'd0, {30'd0, ie, 1'b0});
    endtask

    task automatic clear_flags();
        bus_write(3'd3, 32'h300);
        m_err = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input int bound, input string name);
        int n = 0;
        while (sns_req !== lvl && n < bound) begin @(negedge clk); n++; end
        check(name, 32'(sns_req), 32'(lvl));
    endtask

    task automatic wait_done();
        logic [31:0] d;
        bit got = 1'b0;
        for (int n = 0; n < 300; n++) begin
            bus_read(3'd3, d);
            if (d[8]) begin got = 1'b1; break; end
        end
        check("done_wait", 32'(got), 32'd1);
    endtask

    // Compare STATUS/LAST/pins against the average and hysteresis rules.
    task automatic check_batch(input bit ie, output logic [31:0] st);
        int s = 0, avg, hon, foff;
        bit hs, fs;
        logic [31:0] last;
        for (int i = 0; i < 4; i++) s += int'(batch[i]);
        avg  = s / 4;
        hon  = (m_tl + m_hy > 255) ? 255 : m_tl + m_hy;
        foff = (m_th - m_hy < 0) ? 0 : m_th - m_hy;
        hs = (avg < m_tl);
        fs = (avg > m_th);
        if (hs) m_h = 1'b1; else if (avg >= hon) m_h = 1'b0;
        if (fs) m_f = 1'b1; else if (avg <= foff) m_f = 1'b0;
        if (m_tl > m_th) begin m_h = 1'b0; m_f = 1'b0; end
        else if (m_h && m_f) begin if (hs) m_f = 1'b0; else m_h = 1'b0; end
        m_last = int'(batch[3]);
        bus_read(3'd3, st);
        bus_read(3'd4, last);
        check("avg",        32'(st[7:0]),  32'(avg));
        check("done",       32'(st[8]),    32'd1);
        check("err",        32'(st[9]),    32'(m_err));
        check("st_heater",  32'(st[10]),   32'(m_h));
        check("st_fan",     32'(st[11]),   32'(m_f));
        check("last",       last,          32'(m_last));
        check("heater_pin", 32'(heater_on), 32'(m_h));
        check("fan_pin",    32'(fan_on),    32'(m_f));
        check("irq",        32'(irq),       32'(ie));
    endtask

    task automatic run_batch(input bit ie, output logic [31:0] st);
        for (int i = 0; i < 4; i++) sample_q.push_back(batch[i]);
        start(ie);
        wait_done();
        stop(ie);
        check_batch(ie, st);
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        batch[0] = a; batch[1] = b; batch[2] = c; batch[3] = d;
    endtask

    task automatic measure_gap(input int p, output int gap);
        bus_write(3'd1, 32'(p));
        for (int i = 0; i < 3; i++) sample_q.push_back(8'd0);
        start(1'b0);
        wait_req(1'b1, 50, "gap_rise");
        wait_req(1'b0, 50, "gap_fall");
        gap = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sns_req) break;
            gap++;
        end
        check("gap_rise2", 32'(sns_req), 32'd1);
        stop(1'b0);
        sample_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, st;
        int hi, g0, g1, g4;

        vecs[0]  = '{1'b0, 3'd0, 32'h0};
        vecs[1]  = '{1'b0, 3'd1, 32'h3E8};
        vecs[2]  = '{1'b0, 3'd2, 32'h21E12};
        vecs[3]  = '{1'b0, 3'd3, 32'h0};
        vecs[4]  = '{1'b0, 3'd4, 32'h0};
        vecs[5]  = '{1'b0, 3'd5, 32'h0};
        vecs[6]  = '{1'b0, 3'd7, 32'h0};
        vecs[7]  = '{1'b1, 3'd1, 32'hABCD1234};
        vecs[8]  = '{1'b0, 3'd1, 32'h1234};
        vecs[9]  = '{1'b1, 3'd2, 32'hFFFF0A05};
        vecs[10] = '{1'b0, 3'd2, 32'hF0A05};
        vecs[11] = '{1'b1, 3'd6, 32'hFFFFFFFF};
        vecs[12] = '{1'b0, 3'd6, 32'h0};
        vecs[13] = '{1'b1, 3'd0, 32'hFFFFFFFC};
        vecs[14] = '{1'b0, 3'd0, 32'h0};
        vecs[15] = '{1'b1, 3'd3, 32'hFFFFFFFF};
        vecs[16] = '{1'b0, 3'd3, 32'h0};
        vecs[17] = '{1'b1, 3'd0, 32'h2};
        vecs[18] = '{1'b0, 3'd0, 32'h2};
        vecs[19] = '{1'b1, 3'd0, 32'h0};

        bus.address = '0; bus.write = 1'b0; bus.read = 1'b0; bus.writedata = '0;
        sns_ack = 1'b0; sns_data = '0;
        reset_n = 1'b0;
        #23;
        check("rst_sns_req",  32'(sns_req),   32'd0);
        check("rst_heater",   32'(heater_on), 32'd0);
        check("rst_fan",      32'(fan_on),    32'd0);
        check("rst_irq",      32'(irq),       32'd0);
        check("rst_readdata", bus.readdata,   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_sns_req", 32'(sns_req), 32'd0);

        // Register map table.
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("regmap[%0d]", i), rd, vecs[i].data);
            end
        end
        bus_write(3'd1, 32'd4);
        set_thresh(18, 30, 2);

        // Basic four-sample average.
        fill(8'd20, 8'd21, 8'd22, 8'd23);
        run_batch(1'b0, st);
        check("b031_avg", 32'(st[7:0]), 32'd21);
        check("b031_heater", 32'(heater_on), 32'd0);
        clear_flags();

        // Heater set, hysteresis hold, release.
        fill(8'd10, 8'd10, 8'd10, 8'd10); run_batch(1'b0, st); clear_flags();
        check("heat_set", 32'(heater_on), 32'd1);
        fill(8'd19, 8'd19, 8'd19, 8'd19); run_batch(1'b0, st); clear_flags();
        check("heat_hold", 32'(heater_on), 32'd1);
        fill(8'd20, 8'd20, 8'd20, 8'd20); run_batch(1'b0, st); clear_flags();
        check("heat_clr", 32'(heater_on), 32'd0);

        // Fan and interrupt, then done cleared by W1C.
        fill(8'd40, 8'd40, 8'd40, 8'd40); run_batch(1'b1, st);
        check("fan_set", 32'(fan_on), 32'd1);
        check("irq_set", 32'(irq), 32'd1);
        bus_write(3'd3, 32'h100);
        check("irq_clr", 32'(irq), 32'd0);
        bus_read(3'd3, rd);
        check("done_clr", 32'(rd[8]), 32'd0);
        clear_flags();
        stop(1'b0);

        // Sensor never acknowledges: 256-cycle request then timeout.
        start(1'b0);
        wait_req(1'b1, 50, "tmo_rise");
        hi = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!sns_req) break;
            hi++;
        end
        check("tmo_len", 32'(hi), 32'd256);
        m_err = 1'b1;
        fill(8'd25, 8'd25, 8'd25, 8'd25);
        for (int i = 0; i < 4; i++) sample_q.push_back(batch[i]);
        wait_done();
        stop(1'b0);
        check_batch(1'b0, st);
        clear_flags();

        // Disable mid-request drops the partial sum.
        sample_q.push_back(8'd100);
        sample_q.push_back(8'd100);
        start(1'b0);
        for (int n = 0; n < 100 && sample_q.size() > 0; n++) @(negedge clk);
        wait_req(1'b0, 50, "abort_gap");
        wait_req(1'b1, 50, "abort_req");
        stop(1'b0);
        @(negedge clk);
        check("abort_req_low", 32'(sns_req), 32'd0);
        fill(8'd8, 8'd8, 8'd8, 8'd8);
        run_batch(1'b0, st);
        check("fresh_avg", 32'(st[7:0]), 32'd8);
        clear_flags();

        // Acknowledge without a request is ignored.
        force_ack = 1'b1;
        repeat (5) @(negedge clk);
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        bus_read(3'd4, rd);
        check("stray_ack_last", rd, 32'(m_last));

        // Inverted thresholds force both actuators off.
        set_thresh(40, 30, 2);
        @(negedge clk);
        check("inv_heater", 32'(heater_on), 32'd0);
        check("inv_fan",    32'(fan_on),    32'd0);
        fill(8'd5, 8'd5, 8'd5, 8'd5);         run_batch(1'b0, st); clear_flags();
        fill(8'd200, 8'd200, 8'd200, 8'd200); run_batch(1'b0, st); clear_flags();

        // Full-scale samples with saturating heater threshold.
        set_thresh(250, 254, 15);
        fill(8'd255, 8'd255, 8'd255, 8'd255); run_batch(1'b0, st); clear_flags();
        check("max_fan", 32'(fan_on), 32'd1);
        set_thresh(18, 30, 2);

        // PERIOD 0 behaves as 1; each extra PERIOD count adds one cycle.
        measure_gap(0, g0);
        bus_read(3'd1, rd);
        check("period0_read", rd, 32'd0);
        measure_gap(1, g1);
        measure_gap(4, g4);
        check("gap_p0_eq_p1", 32'(g0), 32'(g1));
        check("gap_p4_minus_p1", 32'(g4 - g1), 32'd3);

        // Randomized batches.
        for (int r = 0; r < 40; r++) begin
            int tl, th, hy, base, v;
            bit ie;
            tl   = int'($urandom_range(10, 40));
            th   = int'($urandom_range(5, 60));
            hy   = int'($urandom_range(0, 15));
            base = (r % 8 == 7) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 70));
            ie   = 1'($urandom_range(0, 1));
            set_thresh(tl, th, hy);
            bus_write(3'd1, 32'($urandom_range(0, 5)));
            for (int i = 0; i < 4; i++) begin
                v = base + int'($urandom_range(0, 6)) - 3;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                batch[i] = 8'(v);
            end
            run_batch(ie, st);
            clear_flags();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/temp_sample_ctrl.md
TEMP_SAMPLE_CTRL -- requirements
Module: temp_sample_ctrl

Interface
REQ-001 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have address  input  3  Avalon-MM slave word address.
REQ-004 SHALL have write / read  input  1 each  Avalon-MM strobes, zero wait-state.
REQ-005 SHALL have writedata  input  32  write data; readdata  output  32  registered read data.
REQ-006 SHALL have sns_req  output  1  sample request level to temperature sensor interface.
REQ-007 SHALL have sns_ack  input  1  sensor data-valid acknowledge; sns_data  input  8  unsigned temperature, deg C.
REQ-008 SHALL have heater_on, fan_on  output  1 each  actuator drives; irq  output  1  level interrupt.

Function -- register map (unmapped addresses read 0, writes ignored)
REQ-009 SHALL decode addr 0 CTRL RW: bit0 enable (rst 0), bit1 irq_en (rst 0).
REQ-010 SHALL decode addr 1 PERIOD RW [15:0]: sample interval in clk cycles, rst 0x03E8; value 0 treated as 1; new value used at next reload.
REQ-011 SHALL decode addr 2 THRESH RW: [7:0] t_low rst 18, [15:8] t_high rst 30, [19:16] hyst rst 2.
REQ-012 SHALL decode addr 3 STATUS: [7:0] avg (R), [8] done (W1C), [9] timeout err (W1C), [10] heater_on (R), [11] fan_on (R).
REQ-013 SHALL decode addr 4 LAST R: [7:0] last accepted raw sample; reset 0.
REQ-014 SHALL register readdata: value for address sampled at cycle N appears at cycle N+1; unused bits 0.
REQ-015 SHALL give W1C precedence to hardware set when both occur in same cycle (flag stays 1).

Function -- sequencer
REQ-016 SHALL implement FSM states IDLE, WAIT_TICK, REQ, ACCUM, UPDATE.
REQ-017 IDLE -> WAIT_TICK when enable=1, loading 16-bit down-counter with PERIOD.
REQ-018 WAIT_TICK -> REQ when counter reaches 1 (exactly PERIOD cycles per sample slot).
REQ-019 REQ: sns_req=1; on first cycle sns_ack=1, capture sns_data into LAST and accumulator, go ACCUM; sns_req low next cycle.
REQ-020 REQ: 8-bit timeout counter; 256 cycles without ack -> set err, discard sample, go WAIT_TICK, sample count unchanged.
REQ-021 SHALL ignore sns_ack whenever sns_req=0.
REQ-022 ACCUM: 10-bit sum, 2-bit count; count 3 -> UPDATE, else WAIT_TICK (reload counter).
REQ-023 UPDATE (one cycle): avg = sum[9:2] (truncate), set done, clear sum/count, update actuators, -> WAIT_TICK.
REQ-024 Heater: set when avg < t_low; clear when avg >= min(t_low+hyst,255); else hold.
REQ-025 Fan: set when avg > t_high; clear when avg <= max(t_high-hyst,0); else hold.
REQ-026 SHALL force heater_on=fan_on=0 when t_low > t_high; outputs never both 1.
REQ-027 irq = irq_en & (done | err), combinational from registered flags.
REQ-028 enable cleared in any state: next cycle IDLE, sns_req=0, sum/count/timeout cleared; heater_on/fan_on/avg hold.

Reset
REQ-029 SHALL on reset_n=0 asynchronously force FSM IDLE, all counters 0, readdata 0, sns_req/heater_on/fan_on/irq 0, registers to stated reset values.
REQ-030 SHALL release reset synchronously-safe: no output change other than defined reset values until first enable.

Verification
REQ-031 PERIOD=4, enable=1, sensor acks 1 cycle after req with 20,21,22,23 -> avg=21, done=1, LAST=23, heater_on=0, fan_on=0.
REQ-032 Samples 10,10,10,10 with t_low=18 -> heater_on=1; next samples 19,19,19,19 (hyst 2) -> heater holds 1; 20x4 -> heater_on=0.
REQ-033 Samples 40x4, t_high=30 -> fan_on=1; irq_en=1 -> irq=1; write STATUS 0x100 -> done=0, irq=0.
REQ-034 sns_ack held 0 -> sns_req drops after 256 cycles, err=1, sample count unchanged; next acked sample accepted normally.
REQ-035 Clear enable while sns_req=1 -> sns_req=0 next cycle, FSM IDLE; re-enable -> fresh 4-sample average.
REQ-036 t_low=40, t_high=30 with any avg -> heater_on=fan_on=0; PERIOD=0 -> one sample slot per cycle.
